// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch capture block: the FSM state encoding
// and the default counter/result width.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  // Default counter/result width.
  localparam int unsigned SW_DEFAULT_WIDTH = 24;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sw_state_e;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_satinc.sv
// -----------------------------------------------------------------------------
// stopwatch_satinc
// Saturating incrementer: returns value+1, or holds at all-ones when the input
// is already all-ones. The saturated flag tells the caller that the increment
// had to be held.
//
// Ports:
//   i_value   : input value
//   o_value_c : saturating value+1 (combinational)
//   o_sat_c   : 1 when i_value is all-ones (combinational)
// -----------------------------------------------------------------------------
module stopwatch_satinc
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = SW_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_value_c,
  output logic             o_sat_c
);

  logic w_all_ones;

  assign w_all_ones = &i_value;
  assign o_sat_c    = w_all_ones;
  assign o_value_c  = w_all_ones ? i_value : i_value + WIDTH'(1);

endmodule : stopwatch_satinc

// File: rtl/stopwatch_capture.sv
// -----------------------------------------------------------------------------
// stopwatch_capture
// Cycle stopwatch. A start pulse begins a measurement, a stop pulse captures
// the number of rising edges from the start-sampling edge to the
// stop-sampling edge. The captured result is held valid until acknowledged.
// The live count saturates at all-ones and raises a sticky overflow flag.
//
// Optional feature macro: STOPWATCH_LAP_EN adds lap capture
// (input lap, outputs lap_count / lap_valid).
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset (highest priority)
//   start        : begin a measurement (accepted in IDLE only)
//   stop         : end a measurement (accepted in RUN only)
//   clear        : synchronous abort, zeroes all state
//   result_ack   : consumer acknowledge of a valid result
//   count        : live elapsed-cycle count
//   result       : captured elapsed cycles
//   result_valid : result valid, held until result_ack
//   busy         : high while in RUN
//   overflow     : sticky, count saturated during the measurement
//   lap          : (lap build) capture a lap time while running
//   lap_count    : (lap build) captured lap time
//   lap_valid    : (lap build) one-cycle pulse when lap_count updates
// -----------------------------------------------------------------------------
module stopwatch_capture
  import stopwatch_pkg::*;
#(
  parameter int unsigned WIDTH = SW_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             result_ack,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             overflow
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic             lap,
  output logic [WIDTH-1:0] lap_count,
  output logic             lap_valid
`endif
);

  sw_state_e        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_busy;
  logic             r_overflow;
`ifdef STOPWATCH_LAP_EN
  logic [WIDTH-1:0] r_lap_count;
  logic             r_lap_valid;
`endif

  logic [WIDTH-1:0] w_count_inc;
  logic             w_count_sat;

  // One incrementer feeds the count, result and lap capture paths, so a stop
  // and a lap in the same cycle always see the identical value.
  stopwatch_satinc #(
    .WIDTH (WIDTH)
  ) u_count_inc (
    .i_value   (r_count),
    .o_value_c (w_count_inc),
    .o_sat_c   (w_count_sat)
  );

  // Measurement FSM with registered outputs; rst beats clear beats the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overflow     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap_count    <= '0;
      r_lap_valid    <= 1'b0;
`endif
    end else if (clear) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_overflow     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap_count    <= '0;
      r_lap_valid    <= 1'b0;
`endif
    end else begin
`ifdef STOPWATCH_LAP_EN
      // lap_valid is a single-cycle pulse.
      r_lap_valid <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // A stop arriving with start is discarded; result is retained.
          if (start) begin
            r_state    <= RUN;
            r_busy     <= 1'b1;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end

        RUN: begin
          // Count advances on every edge in RUN, including the stop edge.
          r_count <= w_count_inc;
          if (w_count_sat) begin
            r_overflow <= 1'b1;
          end
`ifdef STOPWATCH_LAP_EN
          if (lap) begin
            r_lap_count <= w_count_inc;
            r_lap_valid <= 1'b1;
          end
`endif
          if (stop) begin
            r_result       <= w_count_inc;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= DONE;
          end
        end

        DONE: begin
          // Start is ignored here, even alongside result_ack.
          if (result_ack) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign count        = r_count;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign overflow     = r_overflow;
`ifdef STOPWATCH_LAP_EN
  assign lap_count    = r_lap_count;
  assign lap_valid    = r_lap_valid;
`endif

endmodule : stopwatch_capture

// File: tb/tb_stopwatch_capture.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_capture
// Directed bench for stopwatch_capture. Two instances share one stimulus
// stream: the default 24-bit build and a 4-bit build that saturates quickly.
// Expected results are queued when stop is driven and popped when
// result_valid rises. Lap checks are present when STOPWATCH_LAP_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_capture;

  localparam int unsigned WD = 24;
  localparam int unsigned WS = 4;

  logic clk = 1'b0;
  logic rst, start, stop, clear, result_ack;

  logic [WD-1:0] d_count, d_result;
  logic          d_valid, d_busy, d_ovf;
  logic [WS-1:0] s_count, s_result;
  logic          s_valid, s_busy, s_ovf;
`ifdef STOPWATCH_LAP_EN
  logic          lap;
  logic [WD-1:0] d_lap_count;
  logic          d_lap_valid;
  logic [WS-1:0] s_lap_count;
  logic          s_lap_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int unsigned q_d[$];
  int unsigned q_s[$];

  always #5 clk = ~clk;

  stopwatch_capture dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .result_ack   (result_ack),
    .count        (d_count),
    .result       (d_result),
    .result_valid (d_valid),
    .busy         (d_busy),
    .overflow     (d_ovf)
`ifdef STOPWATCH_LAP_EN
    ,
    .lap          (lap),
    .lap_count    (d_lap_count),
    .lap_valid    (d_lap_valid)
`endif
  );

  stopwatch_capture #(.WIDTH(WS)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .result_ack   (result_ack),
    .count        (s_count),
    .result       (s_result),
    .result_valid (s_valid),
    .busy         (s_busy),
    .overflow     (s_ovf)
`ifdef STOPWATCH_LAP_EN
    ,
    .lap          (lap),
    .lap_count    (s_lap_count),
    .lap_valid    (s_lap_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; observe 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: compare each newly valid result against the queued value.
  logic d_valid_q = 1'b0;
  logic s_valid_q = 1'b0;
  always @(negedge clk) begin
    if (d_valid === 1'b1 && d_valid_q === 1'b0) begin
      if (q_d.size() == 0) check("sb_d_unexpected", 32'(d_result), 32'hFFFF_FFFF);
      else                 check("sb_d_result", 32'(d_result), 32'(q_d.pop_front()));
    end
    if (s_valid === 1'b1 && s_valid_q === 1'b0) begin
      if (q_s.size() == 0) check("sb_s_unexpected", 32'(s_result), 32'hFFFF_FFFF);
      else                 check("sb_s_result", 32'(s_result), 32'(q_s.pop_front()));
    end
    d_valid_q <= d_valid;
    s_valid_q <= s_valid;
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; result_ack = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif

    // Reset for two cycles.
    tick(2);
    check("rst_count",  32'(d_count), 0);
    check("rst_result", 32'(d_result), 0);
    check("rst_valid",  32'(d_valid), 0);
    check("rst_busy",   32'(d_busy), 0);
    check("rst_ovf",    32'(d_ovf), 0);
    check("rst_s_count", 32'(s_count), 0);
    rst = 1'b0;
    tick(1);
    check("idle_busy", 32'(d_busy), 0);

    // Basic measure: stop 10 cycles after start.
    start = 1'b1; tick(1); start = 1'b0;
    check("run_busy", 32'(d_busy), 1);
    check("run_count0", 32'(d_count), 0);
    tick(9);
    check("run_count9", 32'(d_count), 9);
    stop = 1'b1; q_d.push_back(10); q_s.push_back(10);
    tick(1); stop = 1'b0;
    check("basic_result", 32'(d_result), 10);
    check("basic_valid", 32'(d_valid), 1);
    check("basic_busy", 32'(d_busy), 0);
    check("basic_s_result", 32'(s_result), 10);
    tick(3);
    check("done_hold_valid", 32'(d_valid), 1);
    check("done_hold_count", 32'(d_count), 10);
    result_ack = 1'b1; tick(1); result_ack = 1'b0;
    check("ack_valid", 32'(d_valid), 0);
    check("idle_result_kept", 32'(d_result), 10);

    // Stop and ack in IDLE are ignored.
    stop = 1'b1; result_ack = 1'b1; tick(1); stop = 1'b0; result_ack = 1'b0;
    check("idle_stop_busy", 32'(d_busy), 0);
    check("idle_stop_valid", 32'(d_valid), 0);

    // start+stop together in IDLE: RUN only.
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(d_busy), 1);
    check("ss_valid", 32'(d_valid), 0);
    tick(2);
    start = 1'b1; tick(1); start = 1'b0;
    check("run_start_ignored", 32'(d_count), 3);
    stop = 1'b1; q_d.push_back(4); q_s.push_back(4);
    tick(1); stop = 1'b0;
    check("coll_result", 32'(d_result), 4);
    start = 1'b1; result_ack = 1'b1; tick(1); start = 1'b0; result_ack = 1'b0;
    check("done_start_ack_busy", 32'(d_busy), 0);
    check("done_start_ack_valid", 32'(d_valid), 0);
    tick(1);
    check("done_start_ack_stay_idle", 32'(d_busy), 0);

    // Saturation on the 4-bit instance; the 24-bit one keeps counting.
    start = 1'b1; tick(1); start = 1'b0;
    tick(19);
    check("sat_s_count", 32'(s_count), 15);
    check("sat_s_ovf", 32'(s_ovf), 1);
    check("sat_d_count", 32'(d_count), 19);
    check("sat_d_ovf", 32'(d_ovf), 0);
    stop = 1'b1; q_d.push_back(20); q_s.push_back(15);
    tick(1); stop = 1'b0;
    check("sat_s_result", 32'(s_result), 15);
    check("sat_s_count_hold", 32'(s_count), 15);
    check("sat_d_result", 32'(d_result), 20);
    tick(1);
    check("sat_s_ovf_sticky", 32'(s_ovf), 1);
    result_ack = 1'b1; tick(1); result_ack = 1'b0;
    check("sat_ovf_idle", 32'(s_ovf), 1);
    start = 1'b1; tick(1); start = 1'b0;
    check("sat_ovf_cleared", 32'(s_ovf), 0);
    check("sat_restart_count", 32'(s_count), 0);

    // Clear mid-RUN at count 5.
    tick(5);
    check("abort_count5", 32'(d_count), 5);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_count", 32'(d_count), 0);
    check("clear_busy", 32'(d_busy), 0);
    check("clear_ovf", 32'(d_ovf), 0);
    check("clear_result", 32'(d_result), 0);
    clear = 1'b1; start = 1'b1; tick(1); clear = 1'b0; start = 1'b0;
    check("clear_beats_start", 32'(d_busy), 0);

    // Reset in DONE discards the measurement.
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    stop = 1'b1; q_d.push_back(3); q_s.push_back(3);
    tick(1); stop = 1'b0;
    check("pre_rst_valid", 32'(d_valid), 1);
    rst = 1'b1; clear = 1'b1; tick(1); rst = 1'b0; clear = 1'b0;
    check("rst_done_valid", 32'(d_valid), 0);
    check("rst_done_result", 32'(d_result), 0);
    check("rst_done_count", 32'(d_count), 0);

`ifdef STOPWATCH_LAP_EN
    // Lap 3 cycles after start, then lap together with stop at 8.
    lap = 1'b1; tick(1); lap = 1'b0;
    check("lap_idle_ignored", 32'(d_lap_valid), 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    lap = 1'b1; tick(1); lap = 1'b0;
    check("lap_count3", 32'(d_lap_count), 3);
    check("lap_valid_pulse", 32'(d_lap_valid), 1);
    tick(1);
    check("lap_valid_drop", 32'(d_lap_valid), 0);
    tick(3);
    stop = 1'b1; lap = 1'b1; q_d.push_back(8); q_s.push_back(8);
    tick(1); stop = 1'b0; lap = 1'b0;
    check("lap_stop_lap", 32'(d_lap_count), 8);
    check("lap_stop_result", 32'(d_result), 8);
    result_ack = 1'b1; tick(1); result_ack = 1'b0;
`endif

    tick(2);
    check("sb_d_drained", 32'(q_d.size()), 0);
    check("sb_s_drained", 32'(q_s.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stopwatch_capture
